// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch slice: address/word widths, halt word, FSM states.
package fetch_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 16;

  typedef logic [PC_W-1:0]    pc_t;
  typedef logic [INSTR_W-1:0] instr_t;

  // Word that stops fetching when captured.
  localparam instr_t HALT_CODE_DEF = 16'hFFFF;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the ROM address, captures the returned word into a
// one-deep output slot with valid/ready handshake, stops on the halt word, and reloads
// the PC on redirect.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pc_o                fetch address to the ROM (straight from the PC register)
//   code_i              ROM word at pc_o (combinational in the ROM)
//   instr_o/instr_pc_o  captured word and the address it came from
//   instr_valid_o       output slot holds a valid instruction
//   instr_ready_i       decode accepts instr_o this cycle
//   redirect_i          flush and reload PC from redirect_pc_i
//   halted_o            fetch is in HALT state
module instr_fetch
  import fetch_pkg::*;
#(
  parameter pc_t    RESET_PC  = 8'h00,
  parameter instr_t HALT_CODE = HALT_CODE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  pc_o,
  input  logic [15:0] code_i,
  output logic [15:0] instr_o,
  output logic [7:0]  instr_pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [7:0]  redirect_pc_i,
  output logic        halted_o
);

  state_t state_q;
  state_t state_d;

  pc_t    pc_q;
  pc_t    pc_d;
  instr_t instr_q;
  instr_t instr_d;
  pc_t    ipc_q;
  pc_t    ipc_d;
  logic   valid_q;
  logic   valid_d;

  logic   slot_free;
  logic   is_halt_word;

  assign slot_free    = !valid_q || instr_ready_i;
  assign is_halt_word = (code_i == HALT_CODE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect always returns to RUN.
  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      state_d = RUN;
    end else if (state_q == RUN && slot_free && is_halt_word) begin
      state_d = HALT;
    end
  end

  // Next values for PC and the output slot.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    if (redirect_i) begin
      // Flush: any presented instruction is dropped (or counted accepted if ready=1).
      pc_d    = redirect_pc_i;
      valid_d = 1'b0;
    end else if (slot_free) begin
      if (state_q == RUN) begin
        instr_d = code_i;
        ipc_d   = pc_q;
        valid_d = 1'b1;
        // Halt word is presented but the PC stays on it.
        if (!is_halt_word) begin
          pc_d = pc_q + 8'd1;
        end
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= 16'h0000;
      ipc_q   <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o          = pc_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = ipc_q;
  assign instr_valid_o = valid_q;
  assign halted_o      = (state_q == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ROM array beside the DUT, directed scenarios with literal
// expectations, then randomized ready/redirect/reset traffic against a cycle model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pc_o;
  logic [15:0] code_i;
  logic [15:0] instr_o;
  logic [7:0]  instr_pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i = 1'b1;
  logic        redirect_i = 1'b0;
  logic [7:0]  redirect_pc_i = 8'h00;
  logic        halted_o;

  logic [15:0] rom [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb code_i = rom[pc_o];

  instr_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .pc_o          (pc_o),
    .code_i        (code_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .halted_o      (halted_o)
  );

  // Reference model: one-deep slot fed from a ROM, described transaction-wise.
  logic        m_known = 1'b0;
  logic [7:0]  m_pc;
  logic [15:0] m_instr;
  logic [7:0]  m_ipc;
  logic        m_valid;
  logic        m_halted;

  always @(posedge clk) begin
    if (rst) begin
      m_known  = 1'b1;
      m_pc     = 8'h00;
      m_instr  = 16'h0000;
      m_ipc    = 8'h00;
      m_valid  = 1'b0;
      m_halted = 1'b0;
    end else if (m_known) begin
      if (redirect_i) begin
        m_pc     = redirect_pc_i;
        m_valid  = 1'b0;
        m_halted = 1'b0;
      end else if (!m_valid || instr_ready_i) begin
        if (m_halted) begin
          m_valid = 1'b0;
        end else begin
          m_instr = rom[m_pc];
          m_ipc   = m_pc;
          m_valid = 1'b1;
          if (rom[m_pc] == 16'hFFFF) m_halted = 1'b1;
          else m_pc = 8'((int'(m_pc) + 1) % 256);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_known) begin
      chk("model_pc", 32'(pc_o), 32'(m_pc));
      chk("model_valid", 32'(instr_valid_o), 32'(m_valid));
      chk("model_halted", 32'(halted_o), 32'(m_halted));
      if (m_valid) begin
        chk("model_instr", 32'(instr_o), 32'(m_instr));
        chk("model_ipc", 32'(instr_pc_o), 32'(m_ipc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pc"}, 32'(pc_o), 32'h00);
    chk({tag, "_instr"}, 32'(instr_o), 32'h0000);
    chk({tag, "_ipc"}, 32'(instr_pc_o), 32'h00);
    chk({tag, "_valid"}, 32'(instr_valid_o), 32'h0);
    chk({tag, "_halted"}, 32'(halted_o), 32'h0);
  endtask

  task automatic chk_word(input string tag, input logic [15:0] w, input logic [7:0] a);
    chk({tag, "_valid"}, 32'(instr_valid_o), 32'h1);
    chk({tag, "_instr"}, 32'(instr_o), 32'(w));
    chk({tag, "_ipc"}, 32'(instr_pc_o), 32'(a));
  endtask

  task automatic redirect_to(input logic [7:0] a);
    redirect_i    = 1'b1;
    redirect_pc_i = a;
    step();
    redirect_i    = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      rom[i] = (w == 16'hFFFF) ? 16'h0001 : w;
    end
    for (int i = 0; i < 10; i++) rom[i] = 16'(i * 16'h1111);
    rom[10]  = 16'hFFFF;
    rom[255] = 16'h1234;

    // Reset and straight-line stream up to the halt word.
    rst = 1'b1;
    step();
    step();
    chk_reset_vals("reset");
    rst = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      step();
      chk_word("stream", rom[i], 8'(i));
    end
    chk("halt_entry", 32'(halted_o), 32'h1);
    step();
    chk("halt_state", 32'(halted_o), 32'h1);
    chk("halt_pc", 32'(pc_o), 32'd10);
    chk("halt_valid", 32'(instr_valid_o), 32'h0);
    step();
    chk("halt_stays_invalid", 32'(instr_valid_o), 32'h0);

    // Redirect out of HALT.
    redirect_to(8'h02);
    chk("redir_halted", 32'(halted_o), 32'h0);
    chk("redir_pc", 32'(pc_o), 32'h02);
    chk("redir_valid", 32'(instr_valid_o), 32'h0);
    step();
    chk_word("redir_first", 16'h2222, 8'h02);

    // Stall for three cycles with 3333 presented.
    step();
    chk_word("pre_stall", 16'h3333, 8'h03);
    instr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_word("stall_hold", 16'h3333, 8'h03);
      chk("stall_pc", 32'(pc_o), 32'h04);
    end
    instr_ready_i = 1'b1;
    step();
    chk_word("after_stall", 16'h4444, 8'h04);

    // Redirect while stalled drops the held word.
    redirect_to(8'h01);
    step();
    chk_word("hold_1111", 16'h1111, 8'h01);
    instr_ready_i = 1'b0;
    step();
    redirect_i    = 1'b1;
    redirect_pc_i = 8'h05;
    step();
    redirect_i    = 1'b0;
    instr_ready_i = 1'b1;
    chk("drop_valid", 32'(instr_valid_o), 32'h0);
    step();
    chk_word("after_drop", 16'h5555, 8'h05);

    // PC wraps from FF to 00.
    redirect_to(8'hFF);
    step();
    chk_word("wrap_ff", 16'h1234, 8'hFF);
    chk("wrap_pc", 32'(pc_o), 32'h00);
    step();
    chk_word("wrap_00", 16'h0000, 8'h00);

    // Reset in the middle of a stall.
    instr_ready_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk_reset_vals("rst_stall");
    rst = 1'b0;
    instr_ready_i = 1'b1;
    step();
    chk_word("rst_stall_restart", 16'h0000, 8'h00);

    // Reset while halted.
    redirect_to(8'h0A);
    step();
    chk("pre_rst_halted", 32'(halted_o), 32'h1);
    rst = 1'b1;
    step();
    chk_reset_vals("rst_halt");
    rst = 1'b0;
    step();
    chk_word("rst_halt_restart", 16'h0000, 8'h00);

    // Randomized traffic over a fresh ROM, loaded while in reset.
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      rom[i] = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
    end
    step();
    rst = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      instr_ready_i = ($urandom_range(0, 9) < 7);
      redirect_i    = ($urandom_range(0, 19) == 0);
      redirect_pc_i = 8'($urandom);
      rst           = ($urandom_range(0, 199) == 0);
      step();
    end
    rst        = 1'b0;
    redirect_i = 1'b0;
    step();
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
